// File: rtl/mem_fetch_unit.sv
// -----------------------------------------------------------------------------
// mem_fetch_unit
//   Program-counter / instruction-register / old-PC owner for a multicycle core.
//   Shares one memory port between instruction fetch (address = PC) and data
//   access (address = ALU result). The port uses a variable-latency req/ready
//   handshake, and a watchdog aborts a request that waits too long.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   fetch_en            request an instruction fetch at PC
//   data_access/_we     request a data read/write at alu_result
//   alu_result          data address
//   write_data          store data
//   pc_load/pc_target   redirect PC (honoured only while idle)
//   mem_*               shared memory port (req, we, addr, wdata, rdata, ready)
//   pc, old_pc, instr   architectural fetch state
//   instr_valid         one-cycle pulse when instr was updated
//   data_out/data_valid registered load data and its one-cycle done pulse
//   busy                a memory request is outstanding
//   timeout_err         sticky: a request was aborted by the watchdog
//   misalign_err        sticky: a pc_target with nonzero low bits was loaded
// -----------------------------------------------------------------------------
module mem_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               PC_STEP      = 4,
  parameter int               TIMEOUT      = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic             data_access,
  input  logic             data_we,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] write_data,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_target,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] old_pc,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic             misalign_err
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam int               ALIGN_BITS = (PC_STEP > 1) ? $clog2(PC_STEP) : 0;
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IFETCH,
    S_DACCESS
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_wd_cnt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_old_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_mem_we;
  logic             r_instr_valid;
  logic             r_data_valid;
  logic             r_timeout_err;
  logic             r_misalign_err;

  logic             w_busy;
  logic             w_timeout;
  logic [WIDTH-1:0] w_eff_pc;

  assign w_busy    = (r_state != S_IDLE);
  // Completion wins over abort: mem_ready on the last allowed edge still completes.
  assign w_timeout = w_busy && !mem_ready && (r_wd_cnt == CNT_LAST);
  // A same-cycle redirect steers the fetch to the new target.
  assign w_eff_pc  = pc_load ? pc_target : r_pc;

  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (data_access)   w_next_state = S_DACCESS;
        else if (fetch_en) w_next_state = S_IFETCH;
      end
      S_IFETCH, S_DACCESS: begin
        if (mem_ready || w_timeout) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt       <= '0;
      r_pc           <= RESET_VECTOR;
      r_old_pc       <= '0;
      r_instr        <= '0;
      r_data_out     <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_we       <= 1'b0;
      r_instr_valid  <= 1'b0;
      r_data_valid   <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_wd_cnt <= '0;
          if (pc_load) begin
            r_pc <= pc_target;
            if ((pc_target & ALIGN_MASK) != '0) r_misalign_err <= 1'b1;
          end
          if (data_access) begin
            r_mem_addr  <= alu_result;
            r_mem_wdata <= write_data;
            r_mem_we    <= data_we;
          end else if (fetch_en) begin
            r_mem_addr <= w_eff_pc;
            r_mem_we   <= 1'b0;
          end
        end
        S_IFETCH: begin
          if (mem_ready) begin
            r_instr       <= mem_rdata;
            r_old_pc      <= r_pc;
            r_pc          <= r_pc + WIDTH'(PC_STEP);
            r_instr_valid <= 1'b1;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        S_DACCESS: begin
          if (mem_ready) begin
            if (!r_mem_we) r_data_out <= mem_rdata;
            r_data_valid <= 1'b1;
            r_mem_we     <= 1'b0;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_mem_we      <= 1'b0;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        default: r_wd_cnt <= '0;
      endcase
    end
  end

  assign mem_req      = w_busy;
  assign busy         = w_busy;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign pc           = r_pc;
  assign old_pc       = r_old_pc;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign timeout_err  = r_timeout_err;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_fetch_unit
//   Self-checking bench for mem_fetch_unit. Directed scenarios first, then
//   randomized transactions. Expected values come from a transaction-level
//   model (pc/old_pc/instr/data_out/error flags updated per completed request).
// -----------------------------------------------------------------------------
module tb_mem_fetch_unit;

  localparam int          W   = 32;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          STP = 4;
  localparam int          TO  = 15;

  logic          clk;
  logic          reset;
  logic          fetch_en;
  logic          data_access;
  logic          data_we;
  logic [W-1:0]  alu_result;
  logic [W-1:0]  write_data;
  logic          pc_load;
  logic [W-1:0]  pc_target;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ready;
  logic [W-1:0]  pc;
  logic [W-1:0]  old_pc;
  logic [W-1:0]  instr;
  logic          instr_valid;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          busy;
  logic          timeout_err;
  logic          misalign_err;

  mem_fetch_unit #(
    .WIDTH       (W),
    .RESET_VECTOR(RV),
    .PC_STEP     (STP),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .data_access (data_access),
    .data_we     (data_we),
    .alu_result  (alu_result),
    .write_data  (write_data),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .pc          (pc),
    .old_pc      (old_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural reference state.
  logic [31:0] m_pc, m_old_pc, m_instr, m_data_out;
  logic        m_terr, m_merr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = RV;
    m_old_pc   = '0;
    m_instr    = '0;
    m_data_out = '0;
    m_terr     = 1'b0;
    m_merr     = 1'b0;
  endtask

  // No requests; everything else random (mem_ready in idle must be ignored).
  task automatic idle_inputs();
    fetch_en    = 1'b0;
    data_access = 1'b0;
    pc_load     = 1'b0;
    data_we     = 1'($urandom);
    alu_result  = $urandom;
    write_data  = $urandom;
    pc_target   = $urandom;
    mem_rdata   = $urandom;
    mem_ready   = 1'($urandom);
  endtask

  // Requests raised while busy must all be ignored.
  task automatic busy_noise();
    fetch_en    = 1'($urandom);
    data_access = 1'($urandom);
    pc_load     = 1'($urandom);
    data_we     = 1'($urandom);
    alu_result  = $urandom;
    write_data  = $urandom;
    pc_target   = $urandom;
  endtask

  task automatic check_arch(input string tag);
    check({tag, ".pc"},       pc,           m_pc);
    check({tag, ".old_pc"},   old_pc,       m_old_pc);
    check({tag, ".instr"},    instr,        m_instr);
    check({tag, ".data_out"}, data_out,     m_data_out);
    check({tag, ".terr"},     timeout_err,  m_terr);
    check({tag, ".merr"},     misalign_err, m_merr);
    check({tag, ".busy"},     busy,         1'b0);
  endtask

  // Called at posedge+1 with the DUT idle. wait_c = cycles mem_ready stays low
  // before the completing edge; wait_c >= TO means the watchdog fires.
  task automatic txn(input string tag, input bit do_fetch, input bit do_data,
                     input bit we, input bit load, input logic [31:0] target,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int wait_c, input logic [31:0] rdata);
    logic [31:0] exp_addr;
    bit          exp_we;
    bit          active;
    idle_inputs();
    fetch_en    = do_fetch;
    data_access = do_data;
    data_we     = we;
    pc_load     = load;
    pc_target   = target;
    alu_result  = addr;
    write_data  = wdata;
    if (load) begin
      m_pc = target;
      if ((target % STP) != 0) m_merr = 1'b1;
    end
    active   = do_data || do_fetch;
    exp_addr = do_data ? addr : m_pc;
    exp_we   = do_data && we;
    @(posedge clk); #1;
    busy_noise();
    mem_ready = 1'b0;
    check({tag, ".acc_busy"}, busy, active);
    check({tag, ".acc_pc"},   pc,   m_pc);
    check({tag, ".acc_merr"}, misalign_err, m_merr);
    if (active) begin
      check({tag, ".acc_req"},  mem_req,  1'b1);
      check({tag, ".acc_addr"}, mem_addr, exp_addr);
      check({tag, ".acc_we"},   mem_we,   exp_we);
      if (exp_we) check({tag, ".acc_wdata"}, mem_wdata, wdata);
      for (int c = 1; c <= TO; c++) begin
        mem_ready = (c == wait_c + 1);
        mem_rdata = (c == wait_c + 1) ? rdata : $urandom;
        @(posedge clk); #1;
        busy_noise();
        mem_ready = 1'b0;
        if (c == wait_c + 1) begin
          if (do_data) begin
            if (!we) m_data_out = rdata;
          end else begin
            m_old_pc = m_pc;
            m_pc     = m_pc + 32'(STP);
            m_instr  = rdata;
          end
          check({tag, ".done_iv"},  instr_valid, !do_data);
          check({tag, ".done_dv"},  data_valid,  do_data);
          check({tag, ".done_req"}, mem_req,     1'b0);
          check({tag, ".done_we"},  mem_we,      1'b0);
          break;
        end else if (c == TO) begin
          m_terr = 1'b1;
          check({tag, ".to_req"}, mem_req,     1'b0);
          check({tag, ".to_iv"},  instr_valid, 1'b0);
          check({tag, ".to_dv"},  data_valid,  1'b0);
          check({tag, ".to_err"}, timeout_err, 1'b1);
        end else begin
          check({tag, ".hold_req"},  mem_req,  1'b1);
          check({tag, ".hold_addr"}, mem_addr, exp_addr);
          check({tag, ".hold_we"},   mem_we,   exp_we);
          check({tag, ".hold_iv"},   instr_valid | data_valid, 1'b0);
        end
      end
    end
    // One idle cycle: pulses must have dropped, state settled.
    idle_inputs();
    @(posedge clk); #1;
    check({tag, ".post_iv"}, instr_valid, 1'b0);
    check({tag, ".post_dv"}, data_valid,  1'b0);
    check_arch(tag);
  endtask

  initial begin
    logic [31:0] tgt;
    int          r;
    int          wc;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.req", mem_req, 1'b0);
    check("rst.we", mem_we, 1'b0);
    check("rst.addr", mem_addr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.iv", instr_valid, 1'b0);
    check("rst.dv", data_valid, 1'b0);
    check_arch("rst");
    reset = 1'b1;

    // Directed scenarios.
    txn("fetch0", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0050_0093);
    txn("dwrite", 0, 1, 1, 0, 32'h0, 32'h100, 32'hDEAD_BEEF, 3, 32'h1234_5678);
    txn("dread", 0, 1, 0, 0, 32'h0, 32'h104, 32'h0, 1, 32'hCAFE_F00D);
    txn("ld_fetch", 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 0, 32'h1111_2222);
    txn("misalign", 0, 0, 0, 1, 32'h42, 32'h0, 32'h0, 0, 32'h0);
    txn("wrap", 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 2, 32'h3333_4444);
    txn("both_req", 1, 1, 0, 0, 32'h0, 32'h200, 32'h0, 0, 32'h5555_6666);
    txn("last_ok", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, TO - 1, 32'h7777_8888);
    txn("timeout", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 100, 32'h9999_AAAA);

    // Reset asserted in the middle of a data write.
    idle_inputs();
    data_access = 1'b1;
    data_we     = 1'b1;
    alu_result  = 32'h200;
    write_data  = 32'hABCD_0123;
    @(posedge clk); #1;
    busy_noise();
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("mid.busy", busy, 1'b1);
    check("mid.we", mem_we, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst.req", mem_req, 1'b0);
    check("arst.we", mem_we, 1'b0);
    check("arst.addr", mem_addr, 32'h0);
    check_arch("arst");
    idle_inputs();
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    txn("post_rst", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 32'h0BAD_F00D);

    // Randomized transactions.
    for (int i = 0; i < 150; i++) begin
      r   = $urandom_range(0, 9);
      tgt = $urandom;
      if ($urandom_range(0, 4) != 0) tgt = tgt & ~32'h3;
      case ($urandom_range(0, 9))
        0:       wc = TO - 1;
        1:       wc = TO;
        2:       wc = TO + 3;
        default: wc = $urandom_range(0, 3);
      endcase
      txn("rand", (r >= 3) && (r <= 8), r <= 3, 1'($urandom),
          ($urandom_range(0, 3) == 0) || (r == 9), tgt, $urandom, $urandom,
          wc, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%h exp=%h", 32'h1, 32'h0);
    $fatal(1, "simulation time limit");
  end

endmodule
